// File: rtl/uplink_pkg.sv
// Shared constants, FSM state type and word builder for the ground-side uplink transmitter.
package uplink_pkg;

  localparam int UPL_KEY_W  = 5;
  localparam int UPL_WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE,
    SPACE,
    GAP
  } uptx_state_t;

  // Sync bit, then the keycode, its complement and the keycode again.
  function automatic logic [UPL_WORD_W-1:0] upl_build_word(input logic [UPL_KEY_W-1:0] key);
    return {1'b1, key, ~key, key};
  endfunction

endpackage

// File: rtl/uplink_tx_if.sv
// Keycode valid/ready handshake into the uplink transmitter.
// UPLINK_TX_ERRINJ_EN adds a per-keycode err_inj flag.
interface uplink_tx_if;
  import uplink_pkg::*;

  logic                 key_valid;
  logic [UPL_KEY_W-1:0] key_data;
  logic                 key_ready;
`ifdef UPLINK_TX_ERRINJ_EN
  logic                 err_inj;

  modport master (output key_valid, output key_data, output err_inj, input key_ready);
  modport slave  (input key_valid, input key_data, input err_inj, output key_ready);
`else
  modport master (output key_valid, output key_data, input key_ready);
  modport slave  (input key_valid, input key_data, output key_ready);
`endif

endinterface

// File: rtl/uplink_fifo.sv
// Small synchronous FIFO with asynchronous active-low clear and full/empty flags.
module uplink_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uplink_tx.sv
// Uplink transmitter: buffers keycodes and sends each as a 16-bit word of UPL0/UPL1 pulses.
// UPLINK_TX_ERRINJ_EN enables per-word corruption of bit 5 via err_inj.
module uplink_tx
  import uplink_pkg::*;
#(
  parameter int BIT_PERIOD = 20,
  parameter int PULSE_LEN  = 4,
  parameter int GAP_CYCLES = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLOCK,
  input  logic        rst_,
  uplink_tx_if.slave  key,
  input  logic        hold,
  output logic        UPL0,
  output logic        UPL1,
  output logic        busy,
  output logic        word_done
);

`ifdef UPLINK_TX_ERRINJ_EN
  localparam int FIFO_W = UPL_KEY_W + 1;
`else
  localparam int FIFO_W = UPL_KEY_W;
`endif
  localparam int TMAX = (BIT_PERIOD > GAP_CYCLES) ? BIT_PERIOD : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] SPACE_LOAD = TW'(BIT_PERIOD - PULSE_LEN - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

  uptx_state_t           state, state_nx;
  logic [UPL_WORD_W-1:0] shift, shift_nx, load_word;
  logic [3:0]            bit_cnt, bit_cnt_nx;
  logic [TW-1:0]         timer, timer_nx;
  logic [FIFO_W-1:0]     key_q, fifo_wr, fifo_rd;
  logic                  ready_en, full, empty, pop, done_nx;

  // key_ready stays low through reset and rises on the first edge after release.
  assign key.key_ready = ready_en && !full;
  assign busy          = (state != IDLE) || !empty;

`ifdef UPLINK_TX_ERRINJ_EN
  assign fifo_wr = {key.err_inj, key.key_data};
`else
  assign fifo_wr = key.key_data;
`endif

  uplink_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FIFO_W)) u_fifo (
    .clk     (CLOCK),
    .rst_n   (rst_),
    .wr_en   (key.key_valid && key.key_ready),
    .wr_data (fifo_wr),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    load_word = upl_build_word(key_q[UPL_KEY_W-1:0]);
`ifdef UPLINK_TX_ERRINJ_EN
    // Flipping the LSB of the complement field makes the receiver's check fail.
    if (key_q[UPL_KEY_W]) load_word[5] = ~load_word[5];
`endif
  end

  always_comb begin
    state_nx   = state;
    shift_nx   = shift;
    bit_cnt_nx = bit_cnt;
    timer_nx   = timer;
    done_nx    = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !hold) begin
          pop      = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        shift_nx   = load_word;
        bit_cnt_nx = 4'd15;
        timer_nx   = PULSE_LOAD;
        state_nx   = PULSE;
      end
      PULSE: begin
        if (timer == '0) begin
          timer_nx = SPACE_LOAD;
          state_nx = SPACE;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      SPACE: begin
        if (timer != '0) begin
          timer_nx = timer - 1'b1;
        end else if (bit_cnt == 4'd0) begin
          timer_nx = GAP_LOAD;
          done_nx  = 1'b1;
          state_nx = GAP;
        end else begin
          shift_nx   = {shift[UPL_WORD_W-2:0], 1'b0};
          bit_cnt_nx = bit_cnt - 4'd1;
          timer_nx   = PULSE_LOAD;
          state_nx   = PULSE;
        end
      end
      GAP: begin
        if (timer == '0) state_nx = IDLE;
        else             timer_nx = timer - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      timer     <= '0;
      key_q     <= '0;
      ready_en  <= 1'b0;
      UPL0      <= 1'b0;
      UPL1      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_nx;
      shift     <= shift_nx;
      bit_cnt   <= bit_cnt_nx;
      timer     <= timer_nx;
      ready_en  <= 1'b1;
      if (pop) key_q <= fifo_rd;
      UPL1      <= (state_nx == PULSE) &&  shift_nx[UPL_WORD_W-1];
      UPL0      <= (state_nx == PULSE) && !shift_nx[UPL_WORD_W-1];
      word_done <= done_nx;
    end
  end

endmodule

// File: tb/tb_uplink_tx.sv
// Self-checking bench for uplink_tx: decodes UPL0/UPL1 pulses into words and scores them against a queue.
module tb_uplink_tx;

  localparam int BIT_PERIOD = 20;
  localparam int PULSE_LEN  = 4;
  localparam int GAP_CYCLES = 40;
  localparam int WORD_CYC   = 16 * BIT_PERIOD;

  logic CLOCK = 1'b0;
  logic rst_  = 1'b0;
  logic hold  = 1'b0;
  logic UPL0, UPL1, busy, word_done;

  uplink_tx_if kif ();

  uplink_tx #(
    .BIT_PERIOD (BIT_PERIOD),
    .PULSE_LEN  (PULSE_LEN),
    .GAP_CYCLES (GAP_CYCLES),
    .FIFO_DEPTH (4)
  ) dut (
    .CLOCK     (CLOCK),
    .rst_      (rst_),
    .key       (kif),
    .hold      (hold),
    .UPL0      (UPL0),
    .UPL1      (UPL1),
    .busy      (busy),
    .word_done (word_done)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int passed = 0;
  int edge_cnt = 0;

  always @(posedge CLOCK) edge_cnt++;

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edge_cnt);
  endtask

  // Scoreboard and line monitor
  logic [15:0] sb[$];
  int          word_starts[$];
  int          words_rx = 0;
  int          mon_bits = 0;
  int          last_done = 0;
  int          word_start = 0;
  int          last_pulse = 0;
  int          width = 0;
  logic        both = 1'b0;
  logic        prev_hi = 1'b0;
  logic [15:0] acc = '0;
  logic [15:0] exp_word;

  always @(negedge CLOCK) begin
    if (!rst_) begin
      mon_bits = 0;
      width    = 0;
      prev_hi  = 1'b0;
      both     = 1'b0;
    end else begin
      if ((UPL0 || UPL1) && !prev_hi) begin
        if (mon_bits == 0) word_start = edge_cnt;
        else check_output("slot_spacing", edge_cnt - last_pulse, BIT_PERIOD);
        last_pulse = edge_cnt;
        acc        = {acc[14:0], UPL1};
        mon_bits++;
        width = 1;
        both  = UPL0 && UPL1;
        if (mon_bits == 16) begin
          mon_bits = 0;
          word_starts.push_back(word_start);
          words_rx++;
          if (sb.size() == 0) begin
            check_output("sb_underflow", acc, 0);
          end else begin
            exp_word = sb.pop_front();
            check_output("word", acc, exp_word);
          end
        end
      end else if (UPL0 || UPL1) begin
        width++;
        both = both || (UPL0 && UPL1);
      end else if (prev_hi) begin
        check_output("pulse_width", width, PULSE_LEN);
        check_output("exclusive", both, 0);
      end
      prev_hi = UPL0 || UPL1;
      if (word_done) begin
        check_output("done_timing", edge_cnt - word_start, WORD_CYC);
        last_done = edge_cnt;
      end
    end
  end

  function automatic logic [15:0] model_word(input logic [4:0] k);
    return {1'b1, k, ~k, k};
  endfunction

  // Offers one keycode; pushes the expected word on the accepting edge.
  task automatic apply_stimulus(input logic [4:0] k, input logic e, input logic [15:0] exp,
                                output int acc_edge);
    int wait_cyc = 0;
    acc_edge = -1;
    @(negedge CLOCK);
    kif.key_valid = 1'b1;
    kif.key_data  = k;
`ifdef UPLINK_TX_ERRINJ_EN
    kif.err_inj   = e;
`else
    if (e) $display("[TB] error injection requested without UPLINK_TX_ERRINJ_EN");
`endif
    while (acc_edge < 0 && wait_cyc < 1000) begin
      if (kif.key_ready) begin
        @(posedge CLOCK);
        sb.push_back(exp);
        #1 acc_edge = edge_cnt;
      end else begin
        @(negedge CLOCK);
        wait_cyc++;
      end
    end
    if (acc_edge < 0) check_output("accept_timeout", 0, 1);
  endtask

  task automatic release_valid();
    @(negedge CLOCK);
    kif.key_valid = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int i = 0;
    while (words_rx < n && i < budget) begin
      @(negedge CLOCK);
      i++;
    end
    check_output("wait_words", words_rx >= n, 1);
  endtask

  task automatic wait_idle(input int budget, output int idle_edge);
    int i = 0;
    @(negedge CLOCK);
    while ((busy || sb.size() != 0) && i < budget) begin
      @(negedge CLOCK);
      i++;
    end
    idle_edge = edge_cnt;
    check_output("wait_idle", busy, 0);
  endtask

  typedef struct {
    logic [4:0]  key;
    logic [15:0] word;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int a, base, rel, idle_edge, start;
    int acc_e[6];
    logic [4:0] rk;

    tbl[0] = '{5'b10001, 16'hC5D1};
    tbl[1] = '{5'b00000, 16'h83E0};
    tbl[2] = '{5'b11111, 16'hFC1F};
    tbl[3] = '{5'b01010, 16'hAAAA};
    tbl[4] = '{5'b10101, 16'hD555};
    tbl[5] = '{5'b00001, 16'h87C1};

    kif.key_valid = 1'b0;
    kif.key_data  = '0;
`ifdef UPLINK_TX_ERRINJ_EN
    kif.err_inj   = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge CLOCK);
    check_output("rst_upl0", UPL0, 0);
    check_output("rst_upl1", UPL1, 0);
    check_output("rst_word_done", word_done, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_key_ready", kif.key_ready, 0);
    rst_ = 1'b1;
    #1 check_output("ready_before_edge", kif.key_ready, 0);
    @(posedge CLOCK);
    #1 check_output("ready_after_edge", kif.key_ready, 1);

    // Single key: latency, word, busy drop after the gap
    apply_stimulus(5'b10001, 1'b0, 16'hC5D1, a);
    release_valid();
    wait_words(1, 1000);
    check_output("first_pulse_latency", word_starts[0] - a, 2);
    wait_idle(500, idle_edge);
    check_output("gap_to_idle", idle_edge - last_done, GAP_CYCLES);

    // Table vectors back-to-back: fills the FIFO while a word is in flight
    base = words_rx;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(tbl[i].key, 1'b0, tbl[i].word, acc_e[i]);
      if (i == 4) begin
        @(negedge CLOCK);
        check_output("ready_low_when_full", kif.key_ready, 0);
      end
    end
    release_valid();
    check_output("fifth_key_held_off", acc_e[5] - acc_e[0], WORD_CYC + GAP_CYCLES + 4);
    wait_words(base + 6, 4000);
    for (int i = 0; i < 5; i++)
      check_output("back_to_back_spacing", word_starts[base + i + 1] - word_starts[base + i],
                   WORD_CYC + GAP_CYCLES + 2);
    wait_idle(500, idle_edge);

    // hold raised mid-word with a second word queued
    base = words_rx;
    apply_stimulus(5'b10101, 1'b0, 16'hD555, a);
    release_valid();
    for (int i = 0; i < 1000 && mon_bits < 8; i++) @(negedge CLOCK);
    apply_stimulus(5'b01010, 1'b0, 16'hAAAA, a);
    kif.key_valid = 1'b0;
    hold = 1'b1;
    wait_words(base + 1, 1000);
    repeat (100) @(negedge CLOCK);
    check_output("hold_no_start", words_rx * 100 + mon_bits, (base + 1) * 100);
    check_output("hold_busy", busy, 1);
    check_output("hold_lines_low", {UPL1, UPL0}, 0);
    hold = 1'b0;
    rel  = edge_cnt;
    wait_words(base + 2, 1000);
    check_output("hold_release_latency", word_starts[base + 1] - rel, 2);
    wait_idle(500, idle_edge);

    // Async reset while UPL0 is high
    apply_stimulus(5'b00000, 1'b0, 16'h83E0, a);
    apply_stimulus(5'b11111, 1'b0, 16'hFC1F, a);
    release_valid();
    for (int i = 0; i < 1000 && !UPL0; i++) @(negedge CLOCK);
    check_output("saw_upl0", UPL0, 1);
    #2 rst_ = 1'b0;
    #1;
    check_output("async_rst_upl0", UPL0, 0);
    check_output("async_rst_busy", busy, 0);
    check_output("async_rst_ready", kif.key_ready, 0);
    sb.delete();
    @(negedge CLOCK);
    @(negedge CLOCK);
    rst_ = 1'b1;
    @(posedge CLOCK);
    #1;
    check_output("post_rst_busy", busy, 0);
    check_output("post_rst_ready", kif.key_ready, 1);

    // Random keys for ~10k cycles
    start = edge_cnt;
    while (edge_cnt - start < 10000) begin
      rk = 5'($urandom);
      apply_stimulus(rk, 1'b0, model_word(rk), a);
      if ($urandom_range(0, 1) == 1) begin
        kif.key_valid = 1'b0;
        repeat ($urandom_range(0, 400)) @(negedge CLOCK);
      end
    end
    release_valid();
    wait_idle(3000, idle_edge);

`ifdef UPLINK_TX_ERRINJ_EN
    // Flagged word followed by a clean one
    apply_stimulus(5'b00000, 1'b1, 16'h83C0, a);
    apply_stimulus(5'b00000, 1'b0, 16'h83E0, a);
    release_valid();
    wait_idle(1500, idle_edge);
`endif

    check_output("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uplink_tx.md
Name: uplink_tx

Overview:
- Ground-side uplink transmitter; the sending end of the serial uplink path that A19 receives on UPL0/UPL1.
- Accepts 5-bit keycodes over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each keycode as a 16-bit uplink word (sync 1, C, ~C, C), MSB first, as discrete pulses: UPL1 carries 1-bits, UPL0 carries 0-bits.
- Drives A19 directly in module-level benches; also the stimulus source for uplink regression.

Parameters:
- BIT_PERIOD, 20, CLOCK cycles per uplink bit slot; must satisfy BIT_PERIOD > PULSE_LEN.
- PULSE_LEN, 4, CLOCK cycles UPL0/UPL1 held high at the start of each slot; must be >= 1.
- GAP_CYCLES, 40, idle CLOCK cycles after the last bit of a word before the next word may start.
- FIFO_DEPTH, 4, keycode buffer entries; must be a power of 2, >= 2.

Ports:
- CLOCK  in  1  system clock; all state on rising edge.
- rst_  in  1  asynchronous active-low reset.
- key_valid  in  1  keycode offered.
- key_data  in  5  keycode C.
- key_ready  out  1  FIFO can accept; equals !full.
- hold  in  1  inhibits starting a new word; a word in flight always completes.
- UPL0  out  1  0-bit pulse, registered.
- UPL1  out  1  1-bit pulse, registered.
- busy  out  1  high when state != IDLE or FIFO non-empty.
- word_done  out  1  one-cycle pulse on the cycle GAP is entered.

Behaviour:
- Reset asserted (rst_ low) takes effect immediately:
  - UPL0=0, UPL1=0, word_done=0, busy=0, key_ready=0.
  - FIFO flushed, state=IDLE.
  - key_ready rises on the first edge after rst_ deasserts.
- Reset mid-word truncates the word; no partial recovery.
- Accept: a keycode is written on an edge where key_valid && key_ready. No write when full, even if a read happens on the same edge.
- Word format, sent bit15 first: {1'b1, C, ~C, C}.
- FSM:
  - IDLE: if FIFO non-empty && !hold, pop FIFO, go to LOAD.
  - LOAD: load the shift register with the built word, bit_cnt=15, go to PULSE.
  - PULSE: the UPL line selected by the shift register MSB is high for PULSE_LEN cycles, then go to SPACE.
  - SPACE: both lines low for BIT_PERIOD-PULSE_LEN cycles. Then, if bit_cnt==0, go to GAP and pulse word_done; otherwise shift left, decrement bit_cnt, go to PULSE.
  - GAP: both lines low for GAP_CYCLES cycles, then go to IDLE.
- Timing:
  - Handshake accepted at edge N into an idle, empty block → UPL1 goes high after edge N+2. Edge N+1 enters LOAD; edge N+2 enters PULSE with outputs registered.
  - Each word occupies exactly 16*BIT_PERIOD cycles.
  - From entering GAP to the next LOAD: GAP_CYCLES+1 cycles.
- Invariants:
  - UPL0 and UPL1 are never high on the same cycle.
  - Both lines are low in IDLE, LOAD, SPACE and GAP.
- hold:
  - Sampled only in IDLE. hold asserted mid-word or in GAP has no effect until the next IDLE.
  - FIFO writes continue while hold is high.
- Timer: one shared down-counter sized $clog2(max(BIT_PERIOD, GAP_CYCLES)+1). It reloads on every state entry and never wraps.
- Back-to-back words: FIFO entries already present leave no extra gap beyond GAP_CYCLES + IDLE + LOAD.

Optional Feature:
- Macro: UPLINK_TX_ERRINJ_EN.
- With the macro defined:
  - Adds input err_inj (1 bit), stored alongside each FIFO entry.
  - A flagged word is sent with bit 5 (LSB of the ~C field) inverted, so the complement check in the receiver fails.
  - Timing is unchanged.
- Without the macro: no port, no extra FIFO bit; words are always well-formed.

Decomposition:
- Package uplink_pkg holds:
  - Constants UPL_KEY_W=5 and UPL_WORD_W=16.
  - Enum uptx_state_t {IDLE, LOAD, PULSE, SPACE, GAP}.
  - Function upl_build_word(key) returning {1'b1, key, ~key, key}.
- One sub-module, uplink_fifo: parameterised depth/width synchronous FIFO, async active-low clear, with full/empty flags.
- FSM, timer and shift register live in uplink_tx.

Test Plan:
- Single key: key_data=5'b10001 after reset, defaults → UPL1/UPL0 pulse sequence decodes to 16'hC5D1. First UPL1 rise 2 edges after accept. Each pulse is 4 cycles high, slots are 20 cycles, word lasts 320 cycles, then word_done.
- FIFO full: write 5 keys back-to-back while busy → key_ready low after the 4th accept. The 5th key is held off until the first pop. All 5 words are sent in order with exactly 40-cycle gaps plus IDLE/LOAD.
- hold: assert hold in bit 8 of word 1 with word 2 queued → word 1 completes, word 2 does not start. Release hold → LOAD on the next edge after IDLE sees !hold.
- Async reset mid-pulse: drop rst_ during UPL0 high → UPL0 low with no clock edge. FIFO empty and busy=0 after release.
- Exclusivity/idle: random keys for 10k cycles → UPL0&UPL1 never both 1. Pulse widths are always exactly PULSE_LEN. Lines stay low outside PULSE.
- (UPLINK_TX_ERRINJ_EN) key 5'b00000 with err_inj=1 → word 16'h83E0 ^ 16'h0020 = 16'h83C0. The next clean word is 16'h83E0.
